// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the byte-enable data memory of the pipelined RISC-V
// core: RV32I load/store funct3 encodings and helpers that turn an access size
// plus byte lane into byte enables and alignment/legality decisions.
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte enable for an access of the given size starting at lane. Halfwords
    // always land on the lower or upper half selected by lane[1].
    function automatic logic [3:0] be_from_size(input logic [2:0] funct3,
                                                input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (funct3)
            F3_B, F3_BU: be = 4'b0001 << lane;
            F3_H, F3_HU: be = lane[1] ? 4'b1100 : 4'b0011;
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

    // Alignment check; encodings without a defined size never report a
    // misalignment (they are reported as access faults instead).
    function automatic logic is_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] lane);
        logic mis;
        mis = 1'b0;
        case (funct3)
            F3_H, F3_HU: mis = lane[0];
            F3_W:        mis = (lane != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic is_legal_load(input logic [2:0] funct3);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    function automatic logic is_legal_store(input logic [2:0] funct3);
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// -----------------------------------------------------------------------------
// dmem_load_align
// Combinational load formatter: picks the byte or halfword out of a raw 32-bit
// memory word, shifts it down to bit 0 and sign- or zero-extends it.
// Ports:
//   word    in  32  raw memory word
//   funct3  in  3   load encoding (LB/LH/LW/LBU/LHU)
//   lane    in  2   byte offset of the access inside the word
//   data    out 32  extended load result
// -----------------------------------------------------------------------------
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    output logic [31:0] data
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Select the addressed byte/half, then extend according to the encoding.
    // Unknown encodings pass the word through; the memory never registers
    // one for a valid load because faulting loads are forced to a zero word.
    always_comb begin
        byteSel = 8'h00;
        halfSel = 16'h0000;
        data    = word;
        case (lane)
            2'd0:    byteSel = word[7:0];
            2'd1:    byteSel = word[15:8];
            2'd2:    byteSel = word[23:16];
            default: byteSel = word[31:24];
        endcase
        halfSel = lane[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{byteSel[7]}}, byteSel};
            F3_BU:   data = {24'h000000, byteSel};
            F3_H:    data = {{16{halfSel[15]}}, halfSel};
            F3_HU:   data = {16'h0000, halfSel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/data_memory_be.sv
// -----------------------------------------------------------------------------
// data_memory_be
// MEM-stage data memory with RV32I sub-word access (SB/SH/SW, LB/LH/LW/LBU/LHU),
// configurable depth and base address, misalignment/range fault flags and a
// 1-cycle synchronous read with a registered read-valid strobe.
// Ports:
//   clk           in  1   rising-edge clock
//   rst           in  1   asynchronous active-high reset
//   MemRead       in  1   load request this cycle
//   MemWrite      in  1   store request this cycle
//   funct3        in  3   access size / signedness
//   addr          in  32  byte address
//   write_data    in  32  right-aligned store data
//   read_data     out 32  extended load result (holds when no load)
//   read_valid    out 1   read_data valid, one cycle after MemRead
//   misaligned    out 1   registered fault pulse: misaligned request
//   access_fault  out 1   registered fault pulse: out of range / bad funct3
// Build option:
//   DMEM_BYPASS_EN  when defined, a same-cycle load sees the bytes written by
//                   the concurrent non-faulting store (write-before-read).
// -----------------------------------------------------------------------------
module data_memory_be
    import dmem_pkg::*;
#(
    parameter  int          DEPTH_WORDS = 256,
    parameter  logic [31:0] BASE_ADDR   = 32'h0000_0000,
    localparam int          IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        misaligned,
    output logic        access_fault
);

    logic [31:0]      mem [0:DEPTH_WORDS-1];

    logic [31:0]      off;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             inRange;
    logic             req;
    logic             faultAccess;
    logic             faultAlign;
    logic             storeOk;
    logic             loadFault;
    logic [3:0]       be;
    logic [31:0]      wdLanes;
    logic [31:0]      rawWord;
    logic [31:0]      loadWord;

    logic [31:0]      wordQ;
    logic [2:0]       f3Q;
    logic [1:0]       laneQ;

    // Address decode. The offset wraps modulo 2^32, so addresses below the
    // base become huge offsets. Depth is a power of two, so "in range" is just
    // all offset bits above the word index being zero.
    always_comb begin
        off     = addr - BASE_ADDR;
        idx     = off[IDX_W+1:2];
        lane    = off[1:0];
        inRange = (off[31:IDX_W+2] == '0);
    end

    // Request qualification and the fault decisions shared by loads and stores.
    always_comb begin
        req         = MemRead | MemWrite;
        faultAccess = req & (~inRange |
                             (MemRead  & ~is_legal_load(funct3)) |
                             (MemWrite & ~is_legal_store(funct3)));
        faultAlign  = req & is_misaligned(funct3, lane);
        storeOk     = MemWrite & ~faultAccess & ~faultAlign;
        loadFault   = faultAccess | faultAlign;
        be          = be_from_size(funct3, lane);
    end

    // Replicate the right-aligned store data across the lanes so the byte
    // enables alone decide which bytes land in memory.
    always_comb begin
        case (funct3)
            F3_B:    wdLanes = {4{write_data[7:0]}};
            F3_H:    wdLanes = {2{write_data[15:0]}};
            default: wdLanes = write_data;
        endcase
    end

    // Word seen by a load this cycle: either the stored contents, or with the
    // bypass build the contents merged with the bytes of a concurrent store.
    always_comb begin
        rawWord  = mem[idx];
        loadWord = rawWord;
`ifdef DMEM_BYPASS_EN
        for (int i = 0; i < 4; i++) begin
            if (storeOk && be[i]) begin
                loadWord[8*i +: 8] = wdLanes[8*i +: 8];
            end
        end
`endif
    end

    // Memory array and the load pipeline register. Reset clears only the
    // output-side registers; the array keeps its contents, and because writes
    // sit in the non-reset branch no edge during reset can modify it. A
    // faulting load registers a zero word as LW so the formatter yields zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wordQ        <= 32'h0;
            f3Q          <= F3_W;
            laneQ        <= 2'b00;
            read_valid   <= 1'b0;
            misaligned   <= 1'b0;
            access_fault <= 1'b0;
        end else begin
            if (storeOk) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wdLanes[8*i +: 8];
                    end
                end
            end
            if (MemRead) begin
                wordQ <= loadFault ? 32'h0 : loadWord;
                f3Q   <= loadFault ? F3_W  : funct3;
                laneQ <= loadFault ? 2'b00 : lane;
            end
            read_valid   <= MemRead;
            misaligned   <= faultAlign;
            access_fault <= faultAccess;
        end
    end

    dmem_load_align u_align (
        .word   (wordQ),
        .funct3 (f3Q),
        .lane   (laneQ),
        .data   (read_data)
    );

endmodule

// File: tb/tb_data_memory_be.sv
// -----------------------------------------------------------------------------
// tb_data_memory_be
// Self-checking bench for data_memory_be (default 256 words, base 0). Keeps a
// byte-array model of the memory and derives every expected output from the
// RV32I access rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_data_memory_be;

    localparam int DEPTH = 256;
    localparam int BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        read_valid;
    logic        misaligned;
    logic        access_fault;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  refMem [BYTES];
    logic [31:0] lastData;

`ifdef DMEM_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    data_memory_be #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .funct3       (funct3),
        .addr         (addr),
        .write_data   (write_data),
        .read_data    (read_data),
        .read_valid   (read_valid),
        .misaligned   (misaligned),
        .access_fault (access_fault)
    );

    // 10 ns clock; inputs change on the falling edge, outputs sampled 1 ns
    // after the rising edge.
    always #5 clk = ~clk;

    // Compare all four outputs against the expected values.
    task automatic checkOutput(input string tag, input logic [31:0] expData,
                               input logic expValid, input logic expMis,
                               input logic expFault);
        total++;
        assert (read_data === expData) else begin
            bad++;
            $error("[TB] FAIL %s read_data: observed %h expected %h", tag, read_data, expData);
        end
        total++;
        assert (read_valid === expValid) else begin
            bad++;
            $error("[TB] FAIL %s read_valid: observed %b expected %b", tag, read_valid, expValid);
        end
        total++;
        assert (misaligned === expMis) else begin
            bad++;
            $error("[TB] FAIL %s misaligned: observed %b expected %b", tag, misaligned, expMis);
        end
        total++;
        assert (access_fault === expFault) else begin
            bad++;
            $error("[TB] FAIL %s access_fault: observed %b expected %b", tag, access_fault, expFault);
        end
    endtask

    // Check read_data against a hand-computed constant.
    task automatic checkConst(input string tag, input logic [31:0] expData);
        total++;
        assert (read_data === expData) else begin
            bad++;
            $error("[TB] FAIL %s const: observed %h expected %h", tag, read_data, expData);
        end
    endtask

    // Drive one request for one cycle, predict the outcome from the access
    // rules, check after the edge, then commit any store to the model.
    task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd);
        logic [31:0] off;
        logic [31:0] u;
        logic [7:0]  b;
        int          sizeB;
        bit          inRange, legalLd, legalSt, req, fault, mis, storeOk, sgn;

        @(negedge clk);
        MemRead    = rd;
        MemWrite   = wr;
        funct3     = f3;
        addr       = a;
        write_data = wd;

        off     = a - 32'h0;
        inRange = (off < BYTES);
        sizeB   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legalLd = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        legalSt = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
        req     = rd || wr;
        fault   = req && (!inRange || (rd && !legalLd) || (wr && !legalSt));
        mis     = req && legalLd && ((off % sizeB) != 0);
        storeOk = wr && !fault && !mis;

        if (rd) begin
            if (fault || mis) begin
                lastData = 32'h0;
            end else begin
                u = 32'h0;
                for (int k = 0; k < sizeB; k++) begin
                    b = refMem[off + k];
                    if (BYPASS && storeOk) b = wd[8*k +: 8];
                    u = u | (32'(b) << (8 * k));
                end
                sgn = (f3[2] == 1'b0);
                if (sgn && sizeB == 1 && u >= 32'd128)        u = u - 32'd256;
                else if (sgn && sizeB == 2 && u >= 32'd32768) u = u - 32'd65536;
                lastData = u;
            end
        end

        @(posedge clk);
        #1;
        checkOutput(tag, lastData, rd, mis, fault);

        if (storeOk) begin
            for (int k = 0; k < sizeB; k++) refMem[off + k] = wd[8*k +: 8];
        end
    endtask

    initial begin
        logic [2:0]  f3Pick [11];
        logic [31:0] ra;
        int          sel;

        f3Pick = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};

        rst = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        funct3 = 3'd0; addr = 32'h0; write_data = 32'h0;
        lastData = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetHeld", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("resetReleased", 32'h0, 1'b0, 1'b0, 1'b0);

        // Known contents for the low 64 words so random loads never see
        // uninitialised storage.
        for (int w = 0; w < 64; w++) applyStimulus("init", 1'b0, 1'b1, 3'd2, 32'(w * 4), 32'h0);
        checkConst("noLoadYet", 32'h0);

        applyStimulus("swDead", 1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        applyStimulus("lwDead", 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        checkConst("lwDead", 32'hDEADBEEF);

        applyStimulus("sb80", 1'b0, 1'b1, 3'd0, 32'h13, 32'h00000080);
        applyStimulus("lb13", 1'b1, 1'b0, 3'd0, 32'h13, 32'h0);
        checkConst("lb13", 32'hFFFFFF80);
        applyStimulus("lbu13", 1'b1, 1'b0, 3'd4, 32'h13, 32'h0);
        checkConst("lbu13", 32'h00000080);
        applyStimulus("lw10", 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        checkConst("lw10", 32'h80ADBEEF);

        applyStimulus("sh22", 1'b0, 1'b1, 3'd1, 32'h22, 32'h00008001);
        applyStimulus("lh22", 1'b1, 1'b0, 3'd1, 32'h22, 32'h0);
        checkConst("lh22", 32'hFFFF8001);
        applyStimulus("lhu22", 1'b1, 1'b0, 3'd5, 32'h22, 32'h0);
        checkConst("lhu22", 32'h00008001);
        applyStimulus("shMis21", 1'b0, 1'b1, 3'd1, 32'h21, 32'h00001234);
        applyStimulus("lw20", 1'b1, 1'b0, 3'd2, 32'h20, 32'h0);
        checkConst("lw20", 32'h80010000);

        applyStimulus("lwRange400", 1'b1, 1'b0, 3'd2, 32'h400, 32'h0);
        checkConst("lwRange400", 32'h0);
        applyStimulus("ldIllegal011", 1'b1, 1'b0, 3'd3, 32'h40, 32'h0);
        applyStimulus("lwWrapLow", 1'b1, 1'b0, 3'd2, 32'hFFFFFFFC, 32'h0);
        applyStimulus("idle", 1'b0, 1'b0, 3'd2, 32'h10, 32'h0);

        applyStimulus("sw30", 1'b0, 1'b1, 3'd2, 32'h30, 32'h11111111);
        applyStimulus("collide30", 1'b1, 1'b1, 3'd0, 32'h30, 32'h000000AA);
        checkConst("collide30", BYPASS ? 32'hFFFFFFAA : 32'h00000011);
        applyStimulus("lw30after", 1'b1, 1'b0, 3'd2, 32'h30, 32'h0);
        checkConst("lw30after", 32'h111111AA);

        // Reset between a load request and its edge, with a store held during reset.
        applyStimulus("preReset", 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        @(negedge clk);
        MemRead = 1'b1; funct3 = 3'd2; addr = 32'h10;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midResetAsync", 32'h0, 1'b0, 1'b0, 1'b0);
        MemRead = 1'b0; MemWrite = 1'b1; write_data = 32'hCAFEF00D;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("storeDuringReset", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0; MemWrite = 1'b0;
        lastData = 32'h0;
        applyStimulus("lwAfterReset", 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
        checkConst("lwAfterReset", 32'h80ADBEEF);

        // Random mix of loads, stores, collisions, faults and idle cycles.
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 7)      ra = 32'($urandom_range(0, 255));
            else if (sel == 8) ra = 32'h400 + 32'($urandom_range(0, 1023));
            else               ra = 32'hFFFFFF00 + 32'($urandom_range(0, 255));
            applyStimulus("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          f3Pick[$urandom_range(0, 10)], ra, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
